// File: rtl/prog_mem_sequencer.sv
// Instruction memory with a fetch sequencer: accepts word writes while not running,
// then streams words from address 0 up to a halt opcode or the highest written address.
module prog_mem_sequencer #(
  parameter int           AW      = 4,
  parameter int           DW      = 32,
  parameter logic [5:0]   HALT_OP = 6'h3F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          actwr,
  input  logic [AW-1:0] wradress,
  input  logic [DW-1:0] tododato,
  input  logic          ejecu,
  input  logic          stall,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          done,
  output logic          wr_err
);

  // state   | meaning
  // IDLE    | after reset, nothing written yet; ejecu ignored
  // LOADED  | at least one word written; ejecu starts a run
  // RUN     | fetching one word per unstalled cycle; writes rejected
  // HALT    | run finished; writes accepted, ejecu restarts from 0
  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_RUN, S_HALT} state_t;

  state_t state, state_n;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] top;
  logic [AW-1:0] instr_addr;
  logic          loaded;
  logic          wr_ok;
  logic          end_run;
  logic          start;

  assign wr_ok   = actwr && (state != S_RUN);
  assign running = (state == S_RUN);
  // The word on instr ends the run if it is a halt or came from the top address.
  assign end_run = (state == S_RUN) && instr_valid &&
                   ((instr[DW-1:DW-6] == HALT_OP) || (instr_addr == top));
  assign start   = (state != S_RUN) && (state_n == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (actwr) state_n = ejecu ? S_RUN : S_LOADED;
      S_LOADED: if (ejecu && loaded) state_n = S_RUN;
      S_RUN:    if (end_run) state_n = S_HALT;
      S_HALT:   if (ejecu) state_n = S_RUN;
      default:  state_n = S_IDLE;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wradress] <= tododato;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= '0;
      top         <= '0;
      loaded      <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      wr_err      <= actwr && (state == S_RUN);
      done        <= end_run;
      instr_valid <= 1'b0;
      if (wr_ok) begin
        loaded <= 1'b1;
        if (wradress > top) top <= wradress;
      end
      if (state == S_RUN) begin
        if (end_run) begin
          // Any fetch issued alongside the final word is dropped.
          pc <= instr_addr + 1'b1;
        end else if (!stall) begin
          instr       <= mem[pc];
          instr_addr  <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + 1'b1;
        end
      end else if (start) begin
        pc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_sequencer.sv
// Directed bench for prog_mem_sequencer: load/run, halt opcode, stall, rejected
// writes, reset mid-run, simultaneous write+start and full-depth wrap.
module tb_prog_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        actwr;
  logic [3:0]  wradress;
  logic [31:0] tododato;
  logic        ejecu;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        running;
  logic        done;
  logic        wr_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_mem [0:15];

  prog_mem_sequencer dut (
    .clk(clk), .rst(rst), .actwr(actwr), .wradress(wradress), .tododato(tododato),
    .ejecu(ejecu), .stall(stall), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .running(running), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    actwr = 1'b1; wradress = a; tododato = d;
    tick();
    actwr = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_pc"}, {28'b0, pc}, 32'h0);
    chk({tag, "_running"}, {31'b0, running}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
    chk({tag, "_wr_err"}, {31'b0, wr_err}, 32'h0);
  endtask

  // Starts a run (optionally with a simultaneous write) and checks the streamed words.
  task automatic run_prog(input string tag, input int exp_n, input logic [3:0] exp_pc,
                          input int stall_at, input bit with_wr,
                          input logic [3:0] wa, input logic [31:0] wd);
    int got_n = 0;
    bit finished = 1'b0;
    logic [31:0] last = '0;
    ejecu = 1'b1;
    if (with_wr) begin actwr = 1'b1; wradress = wa; tododato = wd; model_mem[wa] = wd; end
    tick();
    ejecu = 1'b0; actwr = 1'b0;
    chk({tag, "_start_running"}, {31'b0, running}, 32'h1);
    chk({tag, "_start_novalid"}, {31'b0, instr_valid}, 32'h0);
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      tick();
      if (instr_valid) begin
        chk($sformatf("%s_word%0d", tag, got_n), instr, (got_n < 16) ? model_mem[got_n] : 32'hxxxx_xxxx);
        got_n++;
        last = instr;
        if (got_n == stall_at) begin
          stall = 1'b1;
          for (int s = 0; s < 2; s++) begin
            tick();
            chk($sformatf("%s_stall%0d_instr", tag, s), instr, last);
            chk($sformatf("%s_stall%0d_valid", tag, s), {31'b0, instr_valid}, 32'h0);
            chk($sformatf("%s_stall%0d_pc", tag, s), {28'b0, pc}, got_n);
          end
          stall = 1'b0;
        end
      end
      if (done) begin
        finished = 1'b1;
        chk({tag, "_done_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_done_instr"}, instr, last);
        chk({tag, "_done_running"}, {31'b0, running}, 32'h0);
        chk({tag, "_done_pc"}, {28'b0, pc}, {28'b0, exp_pc});
      end
    end
    chk({tag, "_finished"}, {31'b0, finished}, 32'h1);
    chk({tag, "_count"}, got_n, exp_n);
    tick();
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
    chk({tag, "_after_valid"}, {31'b0, instr_valid}, 32'h0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; actwr = 1'b0; wradress = '0; tododato = '0; ejecu = 1'b0; stall = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 'x;
    tick(); tick();
    rst = 1'b1;
    check_idle("reset");

    ejecu = 1'b1; tick(); ejecu = 1'b0; tick();
    check_idle("ejecu_unloaded");

    wr(4'd0, 32'hA000_0001); wr(4'd1, 32'hA000_0002); wr(4'd2, 32'hA000_0003);
    run_prog("basic", 3, 4'd3, 0, 1'b0, 4'd0, 32'h0);

    wr(4'd0, 32'hA000_0010); wr(4'd1, 32'hFC00_0000);
    wr(4'd2, 32'hA000_0012); wr(4'd3, 32'hA000_0013);
    run_prog("haltop", 2, 4'd2, 0, 1'b0, 4'd0, 32'h0);

    wr(4'd1, 32'hA000_0011);
    run_prog("stall", 4, 4'd4, 2, 1'b0, 4'd0, 32'h0);

    wr(4'd4, 32'hA000_0014); wr(4'd5, 32'hA000_0015);
    ejecu = 1'b1; tick(); ejecu = 1'b0;
    actwr = 1'b1; wradress = 4'd5; tododato = 32'hDEAD_BEEF; tick(); actwr = 1'b0;
    chk("wrerr_pulse5", {31'b0, wr_err}, 32'h1);
    tick();
    chk("wrerr_clear5", {31'b0, wr_err}, 32'h0);
    actwr = 1'b1; wradress = 4'd9; tododato = 32'h9999_9999; tick(); actwr = 1'b0;
    chk("wrerr_pulse9", {31'b0, wr_err}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin tick(); if (done) seen = 1'b1; end
    chk("wrerr_run_done", {31'b0, seen}, 32'h1);
    chk("wrerr_run_pc", {28'b0, pc}, 32'h6);
    run_prog("rerun", 6, 4'd6, 0, 1'b0, 4'd0, 32'h0);

    ejecu = 1'b1; tick(); ejecu = 1'b0; tick(); tick();
    chk("midrun_running", {31'b0, running}, 32'h1);
    rst = 1'b0; tick(); rst = 1'b1;
    check_idle("midrun_reset");
    tick();
    chk("midrun_nodone", {31'b0, done}, 32'h0);
    chk("midrun_idle", {31'b0, running}, 32'h0);

    run_prog("wr_and_go", 1, 4'd1, 0, 1'b1, 4'd0, 32'h0000_00AA);

    for (int i = 0; i < 16; i++) wr(4'(i), 32'h1000_0000 + 32'(i));
    run_prog("full", 16, 4'd0, 0, 1'b0, 4'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
